// File: rtl/census_accumulator.sv
// census_accumulator: sums per-word zero/one/X/Z counts over a frame and
// hands the totals downstream through a valid/ready handshake.
module census_accumulator #(
  parameter int N         = 20,
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [15:0]      zeros,
  input  logic [15:0]      ones,
  input  logic [15:0]      xs,
  input  logic [15:0]      zs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] tot_zeros,
  output logic [ACC_W-1:0] tot_ones,
  output logic [ACC_W-1:0] tot_xs,
  output logic [ACC_W-1:0] tot_zs,
  output logic [15:0]      word_cnt,
  output logic             err_sum,
  output logic             sat
);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             frame_end;
  logic [17:0]      word_sum;
  logic             word_bad;
  logic [ACC_W-1:0] nz, no, nx, nzz;
  logic             oz, oo, ox, ozz;

  // Returns {overflow, clamped sum}; the sum saturates at all-ones.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [15:0] cnt);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + {{(ACC_W-15){1'b0}}, cnt};
    if (s[ACC_W]) s = '1;
    return s;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Handshake decode, frame-end detection and next-state logic.
  always_comb begin
    state_nxt = state;
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
    accept    = in_valid && (state == ACCUM);
    frame_end = in_last || (({1'b0, word_cnt} + 17'd1) == 17'(FRAME_LEN));
    case (state)
      ACCUM: if (accept && frame_end) state_nxt = DONE;
      DONE:  if (out_ready)           state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Saturating sums and per-word integrity check for the offered word.
  always_comb begin
    {oz,  nz}  = sat_add(tot_zeros, zeros);
    {oo,  no}  = sat_add(tot_ones,  ones);
    {ox,  nx}  = sat_add(tot_xs,    xs);
    {ozz, nzz} = sat_add(tot_zs,    zs);
    word_sum   = {2'b0, zeros} + {2'b0, ones} + {2'b0, xs} + {2'b0, zs};
    word_bad   = (word_sum != 18'(N));
  end

  // Accumulators: clear on reset or result handoff, update on accept.
  always_ff @(posedge clk) begin
    if (rst || (state == DONE && out_ready)) begin
      tot_zeros <= '0;
      tot_ones  <= '0;
      tot_xs    <= '0;
      tot_zs    <= '0;
      word_cnt  <= '0;
      err_sum   <= 1'b0;
      sat       <= 1'b0;
    end else if (accept) begin
      tot_zeros <= nz;
      tot_ones  <= no;
      tot_xs    <= nx;
      tot_zs    <= nzz;
      word_cnt  <= word_cnt + 16'd1;
      err_sum   <= err_sum | word_bad;
      sat       <= sat | oz | oo | ox | ozz;
    end
  end

endmodule

// File: tb/tb_census_accumulator.sv
// Scoreboard bench for census_accumulator: three instances cover the default
// configuration, a narrow saturating accumulator and a 2-word frame stream.
module tb_census_accumulator;

  typedef struct packed {
    logic [31:0] tz, to, tx, tzz;
    logic [15:0] wc;
    logic        err, sat;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid[3], in_last[3], out_ready[3];
  logic [15:0] zeros[3], ones[3], xs[3], zs[3];
  logic        in_ready[3], out_valid[3], err[3], sat[3];
  logic [31:0] tot_z[3], tot_o[3], tot_x[3], tot_zz[3];
  logic [15:0] wc[3];
  logic [16:0] b_tz, b_to, b_tx, b_tzz;

  assign tot_z[1]  = {15'd0, b_tz};
  assign tot_o[1]  = {15'd0, b_to};
  assign tot_x[1]  = {15'd0, b_tx};
  assign tot_zz[1] = {15'd0, b_tzz};

  census_accumulator u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_last(in_last[0]), .zeros(zeros[0]), .ones(ones[0]), .xs(xs[0]), .zs(zs[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .tot_zeros(tot_z[0]), .tot_ones(tot_o[0]), .tot_xs(tot_x[0]), .tot_zs(tot_zz[0]),
    .word_cnt(wc[0]), .err_sum(err[0]), .sat(sat[0]));

  census_accumulator #(.ACC_W(17), .FRAME_LEN(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_last(in_last[1]), .zeros(zeros[1]), .ones(ones[1]), .xs(xs[1]), .zs(zs[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .tot_zeros(b_tz), .tot_ones(b_to), .tot_xs(b_tx), .tot_zs(b_tzz),
    .word_cnt(wc[1]), .err_sum(err[1]), .sat(sat[1]));

  census_accumulator #(.FRAME_LEN(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_last(in_last[2]), .zeros(zeros[2]), .ones(ones[2]), .xs(xs[2]), .zs(zs[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .tot_zeros(tot_z[2]), .tot_ones(tot_o[2]), .tot_xs(tot_x[2]), .tot_zs(tot_zz[2]),
    .word_cnt(wc[2]), .err_sum(err[2]), .sat(sat[2]));

  res_t q0[$], q1[$], q2[$];
  int   n_pass = 0, n_total = 0;
  logic rst_prev = 1'b0;
  logic clr_pend[3] = '{1'b0, 1'b0, 1'b0};

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic res_t qfront(input int d);
    case (d)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void qpop(input int d);
    res_t r;
    case (d)
      0: r = q0.pop_front();
      1: r = q1.pop_front();
      default: r = q2.pop_front();
    endcase
  endfunction

  function automatic void push(input int d, input logic [31:0] tz, to, tx, tzz,
                               input logic [15:0] w, input logic e, s);
    res_t r;
    r = '{tz: tz, to: to, tx: tx, tzz: tzz, wc: w, err: e, sat: s};
    case (d)
      0: q0.push_back(r);
      1: q1.push_back(r);
      default: q2.push_back(r);
    endcase
  endfunction

  // Monitor: every cycle, compare each instance against the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      res_t got, exp;
      got = '{tz: tot_z[d], to: tot_o[d], tx: tot_x[d], tzz: tot_zz[d],
              wc: wc[d], err: err[d], sat: sat[d]};
      if (rst_prev) begin
        n_total++;
        if ({got, in_ready[d], out_valid[d]} !== {148'b0 | 2'b10})
          $display("FAIL reset dut%0d got %h rdy=%b vld=%b want zeros rdy=1 vld=0",
                   d, got, in_ready[d], out_valid[d]);
        else n_pass++;
        clr_pend[d] = 1'b0;
      end else if (qsize(d) != 0) begin
        exp = qfront(d);
        n_total++;
        if ({got, in_ready[d], out_valid[d]} !== {exp, 1'b0, 1'b1})
          $display("FAIL result dut%0d got %h rdy=%b vld=%b want %h rdy=0 vld=1",
                   d, got, in_ready[d], out_valid[d], exp);
        else n_pass++;
        if (out_ready[d]) begin
          qpop(d);
          clr_pend[d] = 1'b1;
        end
      end else if (clr_pend[d]) begin
        n_total++;
        if ({got, in_ready[d], out_valid[d]} !== {148'b0 | 2'b10})
          $display("FAIL cleared dut%0d got %h rdy=%b vld=%b want zeros rdy=1 vld=0",
                   d, got, in_ready[d], out_valid[d]);
        else n_pass++;
        clr_pend[d] = 1'b0;
      end else begin
        n_total++;
        if (out_valid[d] !== 1'b0)
          $display("FAIL idle_valid dut%0d got %b want 0", d, out_valid[d]);
        else n_pass++;
      end
    end
    rst_prev = rst;
  end

  task automatic send(input int d, input logic [15:0] z, o, x, zz, input logic last);
    int n = 0;
    in_valid[d] = 1'b1;
    zeros[d] = z; ones[d] = o; xs[d] = x; zs[d] = zz;
    in_last[d] = last;
    forever begin
      @(negedge clk);
      if (in_ready[d] === 1'b1) break;
      n++;
      if (n > 100) begin
        $display("FAIL send_timeout dut%0d in_ready=%b want 1", d, in_ready[d]);
        $fatal(1, "in_ready stuck low");
      end
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    int n = 0;
    while (qsize(d) != 0) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        $display("FAIL drain_timeout dut%0d pending=%0d want 0", d, qsize(d));
        $fatal(1, "result never handed off");
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; in_last[d] = 1'b0; out_ready[d] = 1'b1;
      zeros[d] = '0; ones[d] = '0; xs[d] = '0; zs[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic 3-word frame closed by in_last.
    send(0, 16'd20, 16'd0, 16'd0, 16'd0, 1'b0);
    send(0, 16'd10, 16'd10, 16'd0, 16'd0, 1'b0);
    send(0, 16'd5, 16'd5, 16'd5, 16'd5, 1'b1);
    push(0, 35, 15, 5, 5, 3, 1'b0, 1'b0);
    wait_drain(0);

    // Full 8-word frame, result held off for 5 cycles.
    out_ready[0] = 1'b0;
    for (int i = 0; i < 8; i++) send(0, 16'd2, 16'd18, 16'd0, 16'd0, 1'b0);
    push(0, 16, 144, 0, 0, 8, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 out_ready[0] = 1'b1;
    wait_drain(0);

    // Integrity error, then a clean frame.
    send(0, 16'd3, 16'd3, 16'd3, 16'd3, 1'b1);
    push(0, 3, 3, 3, 3, 1, 1'b1, 1'b0);
    send(0, 16'd20, 16'd0, 16'd0, 16'd0, 1'b1);
    push(0, 20, 0, 0, 0, 1, 1'b0, 1'b0);
    wait_drain(0);

    // Reset mid-frame, then a 1-word frame.
    send(0, 16'd1, 16'd19, 16'd0, 16'd0, 1'b0);
    send(0, 16'd1, 16'd19, 16'd0, 16'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(0, 16'd7, 16'd6, 16'd5, 16'd2, 1'b1);
    push(0, 7, 6, 5, 2, 1, 1'b0, 1'b0);
    wait_drain(0);

    // Saturation on a 17-bit total; each word also mismatches N.
    for (int i = 0; i < 4; i++) send(1, 16'hFFFF, 16'd0, 16'd0, 16'd0, 1'b0);
    push(1, 32'h1FFFF, 0, 0, 0, 4, 1'b1, 1'b0 | 1'b1);
    wait_drain(1);

    // in_last coinciding with the length limit is a single frame end.
    for (int i = 0; i < 4; i++) send(1, 16'd5, 16'd5, 16'd5, 16'd5, i == 3);
    push(1, 20, 20, 20, 20, 4, 1'b0, 1'b0);
    send(1, 16'd20, 16'd0, 16'd0, 16'd0, 1'b1);
    push(1, 20, 0, 0, 0, 1, 1'b0, 1'b0);
    wait_drain(1);

    // Back-to-back 2-word frames with out_ready held high.
    for (int f = 0; f < 10; f++) begin
      send(2, 16'(2 * f), 16'(20 - 2 * f), 16'd0, 16'd0, 1'b0);
      send(2, 16'(2 * f + 1), 16'(19 - 2 * f), 16'd0, 16'd0, f % 2 == 1);
      push(2, 32'(4 * f + 1), 32'(39 - 4 * f), 0, 0, 2, 1'b0, 1'b0);
    end
    wait_drain(2);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/census_accumulator.md
# census_accumulator

Frame-level accumulator placed directly downstream of the combinational per-word 4-state census stage. The census stage reports zero/one/X/Z counts for each N-bit input word; this block accepts those counts through a valid/ready handshake and sums them over a frame of up to FRAME_LEN words. At frame end it presents the totals, a word count and integrity flags through a second valid/ready handshake, then clears for the next frame.

## Interface
- N, 20, bit width of the word counted upstream; used only for the per-word integrity check
- FRAME_LEN, 8, maximum words per frame (1..65535)
- ACC_W, 32, width of each frame total (≥17)
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream count set valid
- in_ready  output  1  block can accept a count set
- in_last  input  1  marks the final word of a frame; qualified by in_valid
- zeros, ones, xs, zs  input  16 each  per-word counts from the census stage
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream accepts the result
- tot_zeros, tot_ones, tot_xs, tot_zs  output  ACC_W each  frame totals
- word_cnt  output  16  words accepted in the frame
- err_sum  output  1  at least one word had zeros+ones+xs+zs ≠ N
- sat  output  1  at least one total saturated

## Operation
- Two states: ACCUM and DONE. Reset enters ACCUM.
- ACCUM: in_ready=1, out_valid=0. An accept is in_valid && in_ready on a rising edge.
- On accept:
  - Each total is updated as total + count, zero-extended to ACC_W+1 bits.
  - If the sum exceeds 2^ACC_W−1, that total clamps to all-ones and sat sets.
  - word_cnt increments.
  - The four counts are summed at 18 bits and compared with N. A mismatch sets err_sum.
- Frame end: the accept has in_last=1, or word_cnt+1 == FRAME_LEN. Next state is DONE.
- DONE: in_ready=0, out_valid=1, and all outputs hold stable. in_valid and the counts are ignored.
- DONE with out_ready=1 at the edge:
  - Totals, word_cnt, err_sum and sat clear to 0.
  - The state returns to ACCUM, so in_ready=1 on the next cycle.
- err_sum and sat are sticky within a frame. They clear only on result handoff or on rst.
- in_last when word_cnt+1 == FRAME_LEN is a single frame end, not two.
- No words are lost. Upstream stalls while DONE is held.

## Timing
- Reset values: in_ready=1, out_valid=0, all totals=0, word_cnt=0, err_sum=0, sat=0. These apply on the edge where rst=1.
- rst mid-frame or while in DONE discards all accumulated data. An asserted out_valid drops on the next edge.
- Accept throughput is 1 word per cycle in ACCUM.
- Result latency: out_valid rises on the edge that accepts the frame-ending word. It is visible in the following cycle.
- Minimum frame turnaround: 1 DONE cycle when out_ready is already high. The bubble between frames is therefore exactly 1 cycle.
- With FRAME_LEN=1, every accept ends a frame. Sustained rate is 1 word per 2 cycles.
- in_ready is a registered state decode. It has no combinational path from out_ready.
- out_valid does not depend combinationally on in_valid.

## Test plan
- Reset then 3 words (zeros,ones,xs,zs) = (20,0,0,0), (10,10,0,0), (5,5,5,5) with in_last on the third word. Required:
  - out_valid the cycle after the third accept.
  - Totals (35,15,5,5), word_cnt=3, err_sum=0, sat=0.
- 8 words without in_last, with out_ready held low for 5 cycles. Required:
  - DONE after the 8th accept.
  - in_ready=0 and outputs stable for all 5 cycles.
  - After the out_ready pulse: cleared outputs and in_ready=1 on the next cycle.
- Word (3,3,3,3), where the sum 12 ≠ 20. Required: err_sum=1 at frame result. The next frame reports err_sum=0.
- ACC_W=17 and FRAME_LEN=4, fed four words of zeros=0xFFFF. Required: tot_zeros=0x1FFFF and sat=1.
- rst pulse after 2 accepts of a frame. Required:
  - All outputs return to their reset values.
  - A following 1-word frame with in_last reports only that word's counts and word_cnt=1.
- Back-to-back stream with out_ready tied high and FRAME_LEN=2. Required: one idle in_ready=0 cycle between frames, and no word dropped or double-counted over 10 frames.
